// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end for the decode stage.
// Owns the fetch PC, issues pipelined instruction-memory requests under a
// credit limit, buffers in-order responses in a small prefetch FIFO and
// presents one instruction per cycle to the IM_ID flop. Redirects flush the
// FIFO and discard every response still in flight; HLT stops new issue.
module ifetch_queue #(
  parameter int          DEPTH  = 4,
  parameter logic [15:0] RST_PC = 16'h0000,
  parameter logic [4:0]  HLT_OP = 5'h0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_IM_ID,
  input  logic        flow_change_ID_EX,
  input  logic [15:0] dst_ID_EX,
  output logic        im_req,
  output logic [15:0] im_addr,
  input  logic        im_rdy,
  input  logic        im_rvalid,
  input  logic [16:0] im_rdata,
  output logic [16:0] instr,
  output logic [15:0] nxt_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Credit limit: FIFO entries plus outstanding requests may never exceed it.
  localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Fetch-side state
  logic [15:0]      r_fetch_pc;
  logic [15:0]      r_ret_pc;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_halted;

  // Prefetch FIFO: control is reset, storage is not
  logic [16:0]      r_fifo_instr [DEPTH];
  logic [15:0]      r_fifo_pc    [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic [CNT_W:0]   w_inflight;
  logic             w_credit;
  logic             w_req;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [16:0]      w_head_instr;
  logic [15:0]      w_head_pc;
  logic             w_head_hlt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_inflight   = {1'b0, r_count} + {1'b0, r_out_cnt};
  assign w_credit     = (w_inflight < CREDITS);
  assign w_head_instr = r_fifo_instr[r_rptr];
  assign w_head_pc    = r_fifo_pc[r_rptr];
  assign w_head_hlt   = (w_head_instr[16:12] == HLT_OP);

  // Request is held low while reset is asserted so nothing issues from reset.
  assign w_req    = rst_n & ~r_halted & ~flow_change_ID_EX & w_credit;
  assign w_accept = w_req & im_rdy;

  // A response is kept only when no stale responses remain and no redirect is
  // happening this cycle; a redirect-cycle response always belongs to the old
  // stream.
  assign w_push = im_rvalid & ~flow_change_ID_EX & (r_drop_cnt == '0);

  // Redirect has priority over stall, pop and HLT.
  assign w_pop  = ~w_empty & ~stall_IM_ID & ~flow_change_ID_EX;

  assign im_req  = w_req;
  assign im_addr = r_fetch_pc;

  // Present the FIFO head to decode, or a bubble when empty or redirecting.
  always_comb begin
    instr  = 17'h00000;
    nxt_pc = 16'h0000;
    if (!w_empty && !flow_change_ID_EX) begin
      instr  = w_head_instr;
      nxt_pc = w_head_pc + 16'd1;
    end
  end

  // Fetch PC: reload on redirect, advance (with 16-bit wrap) on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RST_PC;
    end else if (flow_change_ID_EX) begin
      r_fetch_pc <= dst_ID_EX;
    end else if (w_accept) begin
      r_fetch_pc <= r_fetch_pc + 16'd1;
    end
  end

  // Return-address counter tags each kept response with its word address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_pc <= RST_PC;
    end else if (flow_change_ID_EX) begin
      r_ret_pc <= dst_ID_EX;
    end else if (w_push) begin
      r_ret_pc <= r_ret_pc + 16'd1;
    end
  end

  // Outstanding-request count: up on acceptance, down on any response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
    end else if (w_accept && !im_rvalid) begin
      r_out_cnt <= r_out_cnt + CNT_W'(1);
    end else if (!w_accept && im_rvalid) begin
      r_out_cnt <= r_out_cnt - CNT_W'(1);
    end
  end

  // Drop count: on redirect every request still outstanding after this
  // cycle's response is stale; later responses consume it one at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (flow_change_ID_EX) begin
      r_drop_cnt <= r_out_cnt - CNT_W'(im_rvalid);
    end else if (im_rvalid && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - CNT_W'(1);
    end
  end

  // Halt latch: set when an HLT leaves the head, cleared by any redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (flow_change_ID_EX) begin
      r_halted <= 1'b0;
    end else if (w_pop && w_head_hlt) begin
      r_halted <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flow_change_ID_EX) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // FIFO storage write: instruction plus its word address.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= im_rdata;
      r_fifo_pc[r_wptr]    <= r_ret_pc;
    end
  end

`ifndef SYNTHESIS
  // Overflow or an unsolicited response means the credit logic is broken.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(w_push && w_full));
      assert (!(im_rvalid && (r_out_cnt == '0)));
    end
  end
`endif

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that feeds the decode stage.
- Owns the fetch PC and drives a pipelined instruction-memory request/response interface.
- Buffers returned 17-bit instructions in a small prefetch FIFO and presents one instruction per cycle to the decode IM_ID flop.
- Honours the decode stall (stall_IM_ID), flow-change redirects (flow_change_ID_EX) and HLT.

Parameters:
- DEPTH, 4, prefetch FIFO entries and maximum outstanding memory requests combined (power of 2, ≥2).
- RST_PC, 16'h0000, fetch address after reset.
- HLT_OP, 5'h0F, opcode value (instr[16:12]) of HLT; must match the decode opcode table.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- stall_IM_ID  input  1  decode cannot accept; hold current head
- flow_change_ID_EX  input  1  taken branch/jump resolved in EX; redirect fetch
- dst_ID_EX  input  16  redirect target word address
- im_req  output  1  instruction memory request valid
- im_addr  output  16  request word address
- im_rdy  input  1  memory accepts request this cycle
- im_rvalid  input  1  response valid; responses return in order, ≥1 cycle after acceptance
- im_rdata  input  17  response instruction
- instr  output  17  instruction to decode (17'h00000 = bubble, LLB R0,#0)
- nxt_pc  output  16  PC+1 of presented instruction (0 when bubble)

Behaviour:
- Reset (async, rst_n low):
  - fetch_pc = RST_PC; FIFO empty; outstanding = 0; drop_cnt = 0; halted = 0.
  - im_req = 0; instr = 0; nxt_pc = 0.
  - Reset mid-transaction abandons all in-flight requests. The memory is reset by the same rst_n.
- Issue:
  - im_req = !halted & !flow_change_ID_EX & (fifo_count + outstanding < DEPTH).
  - im_addr = fetch_pc.
  - Request accepted when im_req & im_rdy: fetch_pc increments by 1 (wraps 16'hFFFF→0) and outstanding increments.
- Response:
  - On im_rvalid, outstanding decrements.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {im_rdata, pc} is pushed into the FIFO, where pc is tracked by a separate return-address counter incremented per kept response.
  - The credit rule guarantees the FIFO never overflows. A push to a full FIFO is a design error and must be flagged by an assertion.
- Present (combinational from FIFO head):
  - If FIFO non-empty and !flow_change_ID_EX: instr = head.instr, nxt_pc = head.pc + 1.
  - Otherwise instr = 0, nxt_pc = 0.
  - Push-to-present latency is 1 cycle: a response pushed in cycle t is visible at instr in cycle t+1. There is no bypass.
- Pop: when FIFO non-empty & !stall_IM_ID & !flow_change_ID_EX. A simultaneous push and pop keeps the count unchanged.
- HLT:
  - When a popped head has instr[16:12] == HLT_OP, halted sets next cycle and im_req is forced low.
  - The remaining FIFO contents still drain; decode flushes them.
- Redirect (flow_change_ID_EX = 1 in cycle t); redirect has priority over stall, pop and HLT:
  - No pop or issue in cycle t.
  - FIFO cleared at end of t.
  - fetch_pc and the return-address counter are loaded with dst_ID_EX.
  - halted cleared, because an HLT fetched in a branch shadow is flushed by decode.
  - drop_cnt = outstanding after the cycle-t response, if any. A cycle-t response is always discarded.
  - First new request issues in t+1.
- Back-to-back redirects: each redirect recomputes drop_cnt from the current outstanding count, so no stale response is ever pushed.
- Stall: head is held while stall_IM_ID is high. Issue continues until credits are exhausted.

Test Plan:
1. Reset, im_rdy = 1, 1-cycle memory returning instr = addr:
   - Requests go out at 0,1,2,…
   - instr shows 0x00000 for the first 2 cycles, then 0x00000, 0x00001, 0x00002… on consecutive cycles, with nxt_pc = 1, 2, 3…
2. Hold stall_IM_ID high for 6 cycles from head 0x00003:
   - instr holds 0x00003.
   - im_req drops once 4 entries are buffered or outstanding.
   - After release, 0x00004… resume with no loss or duplicate.
3. 3-cycle memory latency, redirect to 0x0040 while 3 requests are outstanding:
   - The 3 stale responses are dropped.
   - im_addr = 0x0040 in the next cycle; the next non-bubble instr is 0x00040 with nxt_pc = 0x0041.
4. Redirect in the same cycle as im_rvalid and stall_IM_ID:
   - The response is discarded, instr = 0 that cycle, and fetch resumes at the target.
5. Memory returns HLT_OP at address 5:
   - After it pops, im_req stays 0 indefinitely.
   - A later redirect to 0x0010 resumes fetching at 0x0010.
6. fetch_pc = 0xFFFF is accepted:
   - The next im_addr is 0x0000, and nxt_pc for that instruction is 0x0000.
